// File: rtl/jkx_pkg.sv
// jkx_pkg: shared types and constants for the JK excitation driver.
// Holds the FSM state encoding, the {J,K} excitation constants and the
// check-result helper used by jk_excite_driver.
package jkx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10
  } jkx_state_t;

  // Excitation constants, packed as {J, K}. J=K=1 (toggle) is never driven.
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] RST  = 2'b01;

  // A check fails when the flop missed its target or its outputs are not
  // complementary (Q == Qb indicates a broken flop or wiring fault).
  function automatic logic jkx_check_fail(input logic q, input logic qb, input logic expv);
    return (q != expv) | (q == qb);
  endfunction

endpackage : jkx_pkg

// File: rtl/jk_excite.sv
// jk_excite: combinational excitation table for a JK flip-flop.
// Maps the current Q and the requested next value onto a {J,K} pair using
// only hold/set/reset, so the toggle code is never produced.
module jk_excite
  import jkx_pkg::*;
(
  input  logic       q,
  input  logic       tgt,
  output logic [1:0] jk
);

  // Excitation lookup: transition {Q, next} -> {J, K}
  always_comb begin
    jk = HOLD;
    case ({q, tgt})
      2'b00:   jk = HOLD;
      2'b01:   jk = SET;
      2'b10:   jk = RST;
      2'b11:   jk = HOLD;
      default: jk = HOLD;
    endcase
  end

endmodule : jk_excite

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: drives an external JK flip-flop to a requested value and
// verifies the result through its Q/Qb feedback.
// Sequence per target: IDLE (accept) -> DRIVE (J/K held one cycle) ->
// CHECK (compare, pulse done) -> IDLE. One target every 3 cycles.
// Optional feature: define JKX_ERRCNT_EN to add the saturating err_cnt port.
module jk_excite_driver
  import jkx_pkg::*;
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             J,
  output logic             K,
  input  logic             Q,
  input  logic             Qb,
  output logic             done,
  output logic             err
`ifdef JKX_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  jkx_state_t state_r;
  logic       ready_r;
  logic [1:0] jk_r;
  logic       done_r;
  logic       err_r;
  logic       exp_r;

  logic [1:0] jk_map_s;
  logic [1:0] jk_next_s;
  logic       accept_s;
  logic       fail_s;

`ifdef JKX_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_r;
`else
  // CNT_W only sizes err_cnt; this empty guard keeps the parameter referenced
  // in the build without the counter.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

  jk_excite u_jk_excite (
    .q   (Q),
    .tgt (tgt_bit),
    .jk  (jk_map_s)
  );

  // Next excitation: a non-complementary flop (Q == Qb) gets HOLD, since its
  // current state is unknown; the following check then fails on Q == Qb.
  always_comb begin
    jk_next_s = HOLD;
    if (Q == Qb) begin
      jk_next_s = HOLD;
    end else begin
      jk_next_s = jk_map_s;
    end
  end

  assign accept_s = tgt_valid & ready_r;
  assign fail_s   = jkx_check_fail(Q, Qb, exp_r);

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      jk_r      <= HOLD;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      exp_r     <= 1'b0;
`ifdef JKX_ERRCNT_EN
      err_cnt_r <= {CNT_W{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            exp_r   <= tgt_bit;
            jk_r    <= jk_next_s;
            ready_r <= 1'b0;
            state_r <= DRIVE;
          end else begin
            jk_r    <= HOLD;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        DRIVE: begin
          jk_r    <= HOLD;
          done_r  <= 1'b0;
          ready_r <= 1'b0;
          state_r <= CHECK;
        end
        CHECK: begin
          jk_r    <= HOLD;
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state_r <= IDLE;
          if (fail_s) begin
            err_r <= 1'b1;
`ifdef JKX_ERRCNT_EN
            if (err_cnt_r != {CNT_W{1'b1}}) begin
              err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`endif
          end
        end
        default: begin
          jk_r    <= HOLD;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tgt_ready = ready_r;
  assign J         = jk_r[1];
  assign K         = jk_r[0];
  assign done      = done_r;
  assign err       = err_r;
`ifdef JKX_ERRCNT_EN
  assign err_cnt   = err_cnt_r;
`endif

endmodule : jk_excite_driver
